// File: rtl/flag_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : flag_pkg                                                     |
// | Description : Constants shared by both sides of the flag vending machine   |
// |               display link (display width, blank and terminator bytes).    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package flag_pkg;

  localparam int         DISP_W        = 8;
  localparam logic [7:0] DEF_TERM_BYTE = 8'h7D;  // '}'
  localparam logic [7:0] BLANK_BYTE    = 8'h00;

endpackage
`default_nettype wire

// File: rtl/byte_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : byte_fifo                                                    |
// | Description : First-word-fall-through byte buffer. Pointers carry one      |
// |               extra bit so count = wr - rd distinguishes full from empty.  |
// | Revision    : 1.0 - initial release                                        |
// | Ports       : clk, rst (async, active-low)                                 |
// |               i_push/i_data  write request (ignored when full, no pop)     |
// |               i_pop          remove head (ignored when empty)              |
// |               i_clear        sync flush, wins over push/pop                |
// |               o_data         head byte (0 when empty)                      |
// |               o_count/o_full/o_empty  occupancy                            |
// +----------------------------------------------------------------------------+
module byte_fifo #(
  parameter int DEPTH = 64,
  parameter int W     = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_push,
  input  logic [W-1:0]           i_data,
  input  logic                   i_pop,
  input  logic                   i_clear,
  output logic [W-1:0]           o_data,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_full,
  output logic                   o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] r_mem [DEPTH];
  logic [AW:0]  r_wr;
  logic [AW:0]  r_rd;
  logic         w_do_pop;
  logic         w_do_push;

  assign o_count = r_wr - r_rd;
  assign o_empty = (r_wr == r_rd);
  assign o_full  = (o_count == (AW+1)'(DEPTH));
  assign o_data  = o_empty ? '0 : r_mem[r_rd[AW-1:0]];

  // A pop on a full buffer frees the slot the simultaneous push writes into.
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr <= '0;
      r_rd <= '0;
    end else if (i_clear) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      if (w_do_push) r_wr <= r_wr + (AW+1)'(1);
      if (w_do_pop)  r_rd <= r_rd + (AW+1)'(1);
    end
  end

  // Storage needs no reset: contents are only visible through o_data when non-empty.
  always_ff @(posedge clk) begin
    if (w_do_push && !i_clear) r_mem[r_wr[AW-1:0]] <= i_data;
  end

endmodule
`default_nettype wire

// File: rtl/flag_disp_reader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : flag_disp_reader                                             |
// | Description : Samples the slow vending-machine display bus, debounces each |
// |               byte, logs new non-blank bytes into a FWFT buffer and drains |
// |               it over valid/ready. Sets done on the terminator byte.       |
// | Revision    : 1.0 - initial release                                        |
// | Ports       : clk, rst (async, active-low)                                 |
// |               disp       async display byte                                |
// |               clear      sync flush of buffer, flags and last byte         |
// |               out_data/out_valid/out_ready  output stream                  |
// |               count/full buffer occupancy                                  |
// |               done       sticky, terminator accepted                       |
// |               overflow   sticky, accepted byte dropped on full buffer      |
// +----------------------------------------------------------------------------+
module flag_disp_reader
  import flag_pkg::*;
#(
  parameter int              DEPTH         = 64,
  parameter int              STABLE_CYCLES = 1024,
  parameter logic [DISP_W-1:0] TERM_BYTE   = DEF_TERM_BYTE,
  parameter bit              IGNORE_ZERO   = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DISP_W-1:0]      disp,
  input  logic                   clear,
  output logic [DISP_W-1:0]      out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   done,
  output logic                   overflow
);

  localparam int            CW    = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CW-1:0] C_SAT = CW'(STABLE_CYCLES - 1);

  logic [DISP_W-1:0] r_sync1;
  logic [DISP_W-1:0] r_disp_s;
  logic [DISP_W-1:0] r_cand;
  logic [DISP_W-1:0] r_last;
  logic [DISP_W-1:0] r_acc_byte;
  logic [CW-1:0]     r_cnt;
  logic              r_acc_stb;
  logic              r_done;
  logic              r_ovf;

  logic w_accept;
  logic w_is_blank;
  logic w_push_req;
  logic w_pop;
  logic w_full;
  logic w_empty;

  // The counter saturates at C_SAT, so the accept condition would stay true;
  // updating r_last on the same edge keeps the strobe to a single cycle.
  assign w_accept = (r_cnt == C_SAT) && (r_cand != r_last);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1    <= BLANK_BYTE;
      r_disp_s   <= BLANK_BYTE;
      r_cand     <= BLANK_BYTE;
      r_last     <= BLANK_BYTE;
      r_acc_byte <= BLANK_BYTE;
      r_cnt      <= '0;
      r_acc_stb  <= 1'b0;
    end else begin
      r_sync1  <= disp;
      r_disp_s <= r_sync1;
      if (r_disp_s != r_cand) begin
        r_cand <= r_disp_s;
        r_cnt  <= '0;
      end else if (r_cnt != C_SAT) begin
        r_cnt <= r_cnt + CW'(1);
      end
      r_acc_stb <= w_accept;
      if (w_accept) begin
        r_last     <= r_cand;
        r_acc_byte <= r_cand;
      end
      if (clear) begin
        r_cnt     <= '0;
        r_last    <= BLANK_BYTE;
        r_acc_stb <= 1'b0;
      end
    end
  end

  assign w_is_blank = IGNORE_ZERO && (r_acc_byte == BLANK_BYTE);
  assign w_push_req = r_acc_stb && !w_is_blank && !r_done;
  assign w_pop      = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_done <= 1'b0;
      r_ovf  <= 1'b0;
    end else if (clear) begin
      r_done <= 1'b0;
      r_ovf  <= 1'b0;
    end else begin
      if (w_push_req && w_full && !w_pop) r_ovf <= 1'b1;
      // Terminator sets done whether or not it found room in the buffer.
      if (w_push_req && (r_acc_byte == TERM_BYTE)) r_done <= 1'b1;
    end
  end

  byte_fifo #(
    .DEPTH (DEPTH),
    .W     (DISP_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push_req),
    .i_data  (r_acc_byte),
    .i_pop   (w_pop),
    .i_clear (clear),
    .o_data  (out_data),
    .o_count (count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign out_valid = !w_empty;
  assign full      = w_full;
  assign done      = r_done;
  assign overflow  = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_flag_disp_reader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_flag_disp_reader                                          |
// | Description : Scoreboard bench for flag_disp_reader: stimulus pushes the   |
// |               bytes it expects into a queue, a monitor pops and compares   |
// |               on every valid&ready handshake.                              |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_flag_disp_reader;
  import flag_pkg::*;

  localparam int         DEPTH  = 4;
  localparam int         STABLE = 4;
  localparam logic [7:0] TERM   = 8'h7D;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] disp = 8'h00;
  logic       clear = 1'b0;
  logic       out_ready = 1'b0;
  logic [7:0] out_data;
  logic       out_valid;
  logic [2:0] count;
  logic       full;
  logic       done;
  logic       overflow;

  flag_disp_reader #(
    .DEPTH         (DEPTH),
    .STABLE_CYCLES (STABLE),
    .TERM_BYTE     (TERM),
    .IGNORE_ZERO   (1'b1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .disp      (disp),
    .clear     (clear),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .count     (count),
    .full      (full),
    .done      (done),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: bytes the buffer should deliver, in order.
  logic [7:0] exp_q[$];
  logic [7:0] m_last = 8'h00;
  bit         m_done = 1'b0;
  bit         m_ovf  = 1'b0;
  bit         rnd_ready = 1'b0;
  int         low_run = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // A value that held long enough is logged once unless it repeats the last
  // accepted value, is blank, or arrives after the terminator.
  function automatic void model_accept(input logic [7:0] v);
    if (v == m_last) return;
    m_last = v;
    if (v == 8'h00) return;
    if (m_done) return;
    if (exp_q.size() >= DEPTH) m_ovf = 1'b1;
    else exp_q.push_back(v);
    if (v == TERM) m_done = 1'b1;
  endfunction

  function automatic void model_clear();
    exp_q.delete();
    m_last = 8'h00;
    m_done = 1'b0;
    m_ovf  = 1'b0;
  endfunction

  // Monitor: a handshake seen after the negedge completes at the next posedge.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (rst && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL stream: unexpected byte %0h, nothing expected", out_data);
        end else begin
          chk("stream", {24'h0, out_data}, {24'h0, exp_q.pop_front()});
        end
      end
    end
  end

  task automatic cyc();
    @(negedge clk);
    if (rnd_ready) begin
      if (low_run >= 2 || $urandom_range(0, 1) == 1) begin
        out_ready = 1'b1;
        low_run   = 0;
      end else begin
        out_ready = 1'b0;
        low_run++;
      end
    end
  endtask

  task automatic hold(input logic [7:0] v, input int n);
    disp = v;
    repeat (n) cyc();
  endtask

  task automatic seg(input logic [7:0] v, input int n);
    model_accept(v);
    hold(v, n);
  endtask

  task automatic drain();
    int k;
    rnd_ready = 1'b0;
    out_ready = 1'b1;
    k = 0;
    while (out_valid && k < 50) begin
      cyc();
      k++;
    end
    cyc();
    if (k >= 50) begin
      total++;
      bad++;
      $display("FAIL drain: out_valid still %0b after %0d cycles", out_valid, k);
    end
    out_ready = 1'b0;
    chk("drained_queue", exp_q.size(), 0);
  endtask

  task automatic do_clear();
    seg(8'h00, 10);
    out_ready = 1'b0;
    clear = 1'b1;
    cyc();
    clear = 1'b0;
    model_clear();
    cyc();
  endtask

  initial begin
    logic [7:0] v;
    logic [7:0] seq1 [8];
    seq1 = '{8'h00, 8'h66, 8'h00, 8'h6C, 8'h00, 8'h61, 8'h00, 8'h67};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_valid", out_valid, 0);
    chk("rst_count", count, 0);
    chk("rst_done", done, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_full", full, 0);
    chk("rst_data", out_data, 0);
    rst = 1'b1;
    repeat (5) cyc();

    // Latency: out_valid rises at the 8th edge after the change
    out_ready = 1'b0;
    model_accept(8'h66);
    disp = 8'h66;
    for (int e = 1; e <= 8; e++) begin
      @(posedge clk);
      #1;
      if (e == 7) chk("lat_valid_e7", out_valid, 0);
      if (e == 8) begin
        chk("lat_valid_e8", out_valid, 1);
        chk("lat_data_e8", out_data, 8'h66);
      end
    end
    @(negedge clk);
    drain();

    // Blank-separated sequence, continuous ready
    out_ready = 1'b1;
    foreach (seq1[i]) seg(seq1[i], 10);
    drain();

    // Glitch shorter than the filter window is ignored
    seg(8'h00, 10);
    hold(8'h41, 3);
    hold(8'h00, 10);
    chk("glitch_count", count, 0);
    chk("glitch_valid", out_valid, 0);
    // Long hold logs exactly once
    seg(8'h41, 50);
    chk("repeat_count", count, 1);
    drain();

    // Randomised segments with randomised ready
    rnd_ready = 1'b1;
    for (int s = 0; s < 40; s++) begin
      if ($urandom_range(0, 2) == 0) hold(8'($urandom_range(0, 255)), $urandom_range(1, STABLE - 1));
      v = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 3) == 0) v = 8'h00;
      if (v == TERM) v = 8'h7C;
      seg(v, $urandom_range(STABLE + 4, STABLE + 10));
    end
    drain();
    chk("rand_ovf", overflow, m_ovf);

    // Overflow: five distinct bytes, no consumer
    do_clear();
    seg(8'hA1, 10);
    seg(8'hA2, 10);
    seg(8'hA3, 10);
    seg(8'hA4, 10);
    seg(8'hA5, 10);
    chk("ovf_full", full, 1);
    chk("ovf_count", count, 4);
    chk("ovf_flag", overflow, m_ovf);
    drain();
    chk("ovf_sticky", overflow, 1);
    do_clear();
    chk("clr_ovf", overflow, 0);
    chk("clr_count", count, 0);

    // Push on the full cycle with a simultaneous pop
    seg(8'hB1, 10);
    seg(8'hB2, 10);
    seg(8'hB3, 10);
    seg(8'hB4, 10);
    chk("var_full_before", full, 1);
    disp = 8'hB5;
    repeat (7) @(posedge clk);
    @(negedge clk);
    out_ready = 1'b1;
    #2;
    model_accept(8'hB5);
    @(negedge clk);
    out_ready = 1'b0;
    chk("var_ovf", overflow, 0);
    chk("var_count", count, 4);
    chk("var_full", full, 1);
    drain();

    // Terminator
    do_clear();
    out_ready = 1'b1;
    seg(8'h7B, 10);
    seg(8'h00, 10);
    seg(TERM, 10);
    seg(8'h41, 10);
    chk("term_done", done, m_done);
    drain();
    chk("term_count", count, 0);
    chk("term_done_sticky", done, 1);
    do_clear();
    chk("clr_done", done, 0);
    chk("clr_count2", count, 0);

    // Async reset mid-stream
    seg(8'hC1, 10);
    seg(8'hC2, 10);
    seg(8'hC3, 10);
    chk("mid_count", count, 3);
    rst = 1'b0;
    #1;
    chk("mid_rst_count", count, 0);
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_full", full, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_ovf", overflow, 0);
    model_clear();
    disp = 8'h00;
    repeat (2) cyc();
    rst = 1'b1;
    cyc();
    out_ready = 1'b1;
    seg(8'h52, 10);
    seg(8'h00, 10);
    seg(8'h53, 10);
    drain();
    chk("resume_ovf", overflow, 0);

    chk("leftover", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
